// File: rtl/clk_time_setter_pkg.sv
// Shared types and constants for the front-panel time-set controller.
// Address codes match the clock core's load-port decode.
package clk_time_setter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEditHr,
    StEditMin,
    StEditSec,
    StWrHr,
    StWrMin,
    StWrSec
  } state_e;

  localparam logic [1:0] AddrSec = 2'b00;
  localparam logic [1:0] AddrMin = 2'b01;
  localparam logic [1:0] AddrHr  = 2'b10;

  localparam logic [5:0] MaxHr     = 6'd23;
  localparam logic [5:0] MaxMinSec = 6'd59;

  // Modulo (max+1) step; up=1 increments, up=0 decrements with wrap.
  function automatic logic [5:0] step_mod(input logic [5:0] val, input logic [5:0] max,
                                          input logic up);
    logic [5:0] res;
    if (up) begin
      res = (val >= max) ? 6'd0 : val + 6'd1;
    end else begin
      res = (val == 6'd0) ? max : val - 6'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_btn_edge.sv
// One-bit rising-edge detector on a synchronous, debounced button level.
// A held level produces exactly one edge pulse.
module clk_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/clk_time_setter.sv
// Front-panel time-set controller: edits hr/min/sec shadows from buttons, then
// commits them to the clock core as three back-to-back single-cycle load writes.
module clk_time_setter
  import clk_time_setter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter int unsigned TIMEOUT_W      = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       load,
  output logic [1:0] addrs,
  output logic [5:0] data_out,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic mode_e, inc_e, dec_e;

  clk_btn_edge u_edge_mode (
    .clk   (clk),
    .reset (reset),
    .level (btn_mode),
    .rise  (mode_e)
  );

  clk_btn_edge u_edge_inc (
    .clk   (clk),
    .reset (reset),
    .level (btn_inc),
    .rise  (inc_e)
  );

  clk_btn_edge u_edge_dec (
    .clk   (clk),
    .reset (reset),
    .level (btn_dec),
    .rise  (dec_e)
  );

  state_e               state_q;
  logic [5:0]           hr_q, min_q, sec_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 step;

  // Exactly one of inc/dec: simultaneous edges cancel out.
  assign step = inc_e ^ dec_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hr_q        <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      cnt_q       <= '0;
      load        <= 1'b0;
      addrs       <= AddrSec;
      data_out    <= '0;
      edit_active <= 1'b0;
      edit_field  <= 2'b00;
    end else begin
      load <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mode_e) begin
            state_q     <= StEditHr;
            cnt_q       <= '0;
            edit_active <= 1'b1;
            edit_field  <= AddrHr;
          end
        end
        StEditHr, StEditMin, StEditSec: begin
          if (mode_e) begin
            cnt_q <= '0;
            if (state_q == StEditHr) begin
              state_q    <= StEditMin;
              edit_field <= AddrMin;
            end else if (state_q == StEditMin) begin
              state_q    <= StEditSec;
              edit_field <= AddrSec;
            end else begin
              state_q     <= StWrHr;
              edit_active <= 1'b0;
              edit_field  <= 2'b00;
              load        <= 1'b1;
              addrs       <= AddrHr;
              data_out    <= hr_q;
            end
          end else if (step) begin
            cnt_q <= '0;
            if (state_q == StEditHr) begin
              hr_q <= step_mod(hr_q, MaxHr, inc_e);
            end else if (state_q == StEditMin) begin
              min_q <= step_mod(min_q, MaxMinSec, inc_e);
            end else begin
              sec_q <= step_mod(sec_q, MaxMinSec, inc_e);
            end
          end else if (cnt_q == TimeoutLast) begin
            // Abort without writing; shadows keep what the user entered.
            state_q     <= StIdle;
            cnt_q       <= '0;
            edit_active <= 1'b0;
            edit_field  <= 2'b00;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrHr: begin
          state_q  <= StWrMin;
          load     <= 1'b1;
          addrs    <= AddrMin;
          data_out <= min_q;
        end
        StWrMin: begin
          state_q  <= StWrSec;
          load     <= 1'b1;
          addrs    <= AddrSec;
          data_out <= sec_q;
        end
        StWrSec: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_time_setter.sv
// Directed bench for clk_time_setter with a short edit timeout (16 cycles).
module tb_clk_time_setter;

  logic       clk;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_out;
  logic       edit_active;
  logic [1:0] edit_field;

  int checks;
  int errors;

  clk_time_setter #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .load        (load),
    .addrs       (addrs),
    .data_out    (data_out),
    .edit_active (edit_active),
    .edit_field  (edit_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Levels change at negedge, so each press is one posedge high, then one low.
  task automatic press(input logic m, input logic i, input logic d);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
  endtask

  task automatic press_n(input logic i, input logic d, input int n);
    for (int k = 0; k < n; k++) press(1'b0, i, d);
  endtask

  // Commit from EDIT_SEC and compare the three write cycles plus the idle cycle after.
  task automatic commit_and_check(input string name, input logic [5:0] hr, input logic [5:0] mn,
                                  input logic [5:0] sc);
    logic [8:0] exp_w [3];
    exp_w[0] = {1'b1, 2'b10, hr};
    exp_w[1] = {1'b1, 2'b01, mn};
    exp_w[2] = {1'b1, 2'b00, sc};
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({load, addrs, data_out} !== exp_w[k]) begin
        errors++;
        $display("FAIL %s write%0d: got load=%b addrs=%b data=%0d, need load=%b addrs=%b data=%0d",
                 name, k, load, addrs, data_out, exp_w[k][8], exp_w[k][7:6], exp_w[k][5:0]);
      end
      if (k < 2) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if ({load, edit_active, addrs, data_out} !== {1'b0, 1'b0, 2'b00, sc}) begin
      errors++;
      $display("FAIL %s after_burst: got load=%b edit_active=%b addrs=%b data=%0d, need 0 0 00 %0d",
               name, load, edit_active, addrs, data_out, sc);
    end
  endtask

  task automatic test_reset();
    logic seen;
    seen = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({load, addrs, data_out, edit_active, edit_field} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, need all zero",
               {load, addrs, data_out, edit_active, edit_field});
    end
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (load || edit_active) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_100: got activity=%b, need 0", seen);
    end
  endtask

  task automatic test_basic_edit();
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({edit_active, edit_field} !== 3'b110) begin
      errors++;
      $display("FAIL enter_edit_hr: got active=%b field=%b, need 1 10", edit_active, edit_field);
    end
    press_n(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({edit_active, edit_field} !== 3'b101) begin
      errors++;
      $display("FAIL enter_edit_min: got active=%b field=%b, need 1 01", edit_active, edit_field);
    end
    press_n(1'b0, 1'b1, 2);
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({edit_active, edit_field} !== 3'b100) begin
      errors++;
      $display("FAIL enter_edit_sec: got active=%b field=%b, need 1 00", edit_active, edit_field);
    end
    press_n(1'b1, 1'b0, 1);
    commit_and_check("basic", 6'd3, 6'd58, 6'd1);
  endtask

  // Shadows start at hr=3 min=58 sec=1 from the previous commit.
  task automatic test_wrap();
    press(1'b1, 1'b0, 1'b0);
    press_n(1'b1, 1'b0, 21);  // 3 -> 23 -> 0
    press(1'b1, 1'b0, 1'b0);
    press_n(1'b0, 1'b1, 59);  // 58 -> 0 -> 59
    press(1'b1, 1'b0, 1'b0);
    press_n(1'b1, 1'b0, 59);  // 1 -> 59 -> 0
    commit_and_check("wrap", 6'd0, 6'd59, 6'd0);
  endtask

  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (load) seen = 1'b1;
    end
    checks++;
    if (edit_active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got edit_active=%b, need 1", edit_active);
    end
    @(negedge clk);
    if (load) seen = 1'b1;
    checks++;
    if ({edit_active, edit_field} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_abort: got active=%b field=%b, need 0 00", edit_active, edit_field);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (load || edit_active) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL timeout_no_load: got activity=%b, need 0", seen);
    end
    // A mode press from IDLE must land in EDIT_HR again.
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({edit_active, edit_field} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_reenter: got active=%b field=%b, need 1 10", edit_active, edit_field);
    end
    repeat (20) @(negedge clk);
  endtask

  // Shadows: hr=0 min=59 sec=0.
  task automatic test_priority();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);   // cancels
    @(negedge clk);
    btn_inc = 1'b1;            // held 50 cycles: one step, then timeout
    repeat (50) @(negedge clk);
    btn_inc = 1'b0;
    checks++;
    if (edit_active !== 1'b0) begin
      errors++;
      $display("FAIL held_inc_timeout: got edit_active=%b, need 0", edit_active);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);   // mode wins over inc
    checks++;
    if ({edit_active, edit_field} !== 3'b101) begin
      errors++;
      $display("FAIL mode_inc_same: got active=%b field=%b, need 1 01", edit_active, edit_field);
    end
    press(1'b0, 1'b1, 1'b1);   // cancels on minutes too
    press(1'b1, 1'b0, 1'b0);
    commit_and_check("priority", 6'd1, 6'd59, 6'd0);
  endtask

  task automatic test_reset_mid_burst();
    logic seen;
    seen = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);   // now in WR_HR
    @(posedge clk);
    #1;
    checks++;
    if ({load, addrs} !== 3'b101) begin
      errors++;
      $display("FAIL wr_min_before_reset: got load=%b addrs=%b, need 1 01", load, addrs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({load, addrs, edit_active} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_load: got load=%b addrs=%b active=%b, need 0 00 0",
               load, addrs, edit_active);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (load || edit_active) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL no_wr_sec_after_reset: got activity=%b, need 0", seen);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    reset    = 1'b0;
    test_reset();
    test_basic_edit();
    test_wrap();
    test_timeout();
    test_priority();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
